mips_fetch_dpath_pipe: RTL and testbench

//  Parametrised two-stage (IF/ID) successor of the single-cycle MIPS datapath.
//  - IF stage: owns the PC register.
//  - IF/ID register: with valid bit.
//  - ID stage: decode/operand muxing; resolves branch and jump in ID.
//  - Stall holds both stages; a taken redirect flushes IF/ID with a bubble.

---
 rtl/mips_fetch_dpath_pipe.sv | 106 ++++++++++
 tb/tb_mips_fetch_dpath_pipe.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mips_fetch_dpath_pipe.sv
// rtl/mips_fetch_dpath_pipe.sv - two-stage (IF/ID) MIPS fetch/decode datapath
//
// Purpose: owns the PC (IF) and the IF/ID register, decodes the ID-stage
// instruction, muxes operands and resolves branches/jumps in ID.
// A stall holds both stages; a taken redirect loads the PC with the target
// and flushes IF/ID with a bubble (one-cycle penalty, no delay slot).
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   instr                  imem read data for address pc
//   stall, pcsrc, jmp      hazard hold, branch taken, jump (for ID instr)
//   memtoreg/alusrc/regdst operand and write-back mux selects
//   rd1, rd2               register file read data
//   aluresult, readdata    write-back candidates
//   pc                     fetch address
//   id_valid/id_instr/id_pcplus  IF/ID register contents
//   op, funct, a1, a2, a3  decoded fields / register addresses
//   signimm, srca, srcb    immediate and ALU operands
//   wd3                    register file write data
module mips_fetch_dpath_pipe #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = 4,
  parameter int              BR_SHIFT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instr,
  input  logic            stall,
  input  logic            pcsrc,
  input  logic            jmp,
  input  logic            memtoreg,
  input  logic            alusrc,
  input  logic            regdst,
  input  logic [XLEN-1:0] rd1,
  input  logic [XLEN-1:0] rd2,
  input  logic [XLEN-1:0] aluresult,
  input  logic [XLEN-1:0] readdata,
  output logic [XLEN-1:0] pc,
  output logic            id_valid,
  output logic [31:0]     id_instr,
  output logic [XLEN-1:0] id_pcplus,
  output logic [5:0]      op,
  output logic [5:0]      funct,
  output logic [4:0]      a1,
  output logic [4:0]      a2,
  output logic [4:0]      a3,
  output logic [XLEN-1:0] signimm,
  output logic [XLEN-1:0] srca,
  output logic [XLEN-1:0] srcb,
  output logic [XLEN-1:0] wd3
);

  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);
  // Low bits of the jump target that come from the instruction index
  // (plus the zero shift bits); everything above is kept from id_pcplus.
  // Done with a mask so BR_SHIFT = 0 needs no zero-width concatenation.
  localparam logic [XLEN-1:0] JLOW_MASK = (XLEN'(1) << (26 + BR_SHIFT)) - XLEN'(1);

  logic [XLEN-1:0] pcplus;
  logic [XLEN-1:0] brtarget;
  logic [XLEN-1:0] jtarget;
  logic            redirect;

  assign pcplus   = pc + STEP;
  assign brtarget = id_pcplus + (signimm << BR_SHIFT);
  assign jtarget  = (id_pcplus & ~JLOW_MASK) | (XLEN'(id_instr[25:0]) << BR_SHIFT);
  // A bubble never redirects, and a stalled redirect waits for the stall to drop.
  assign redirect = id_valid & ~stall & (jmp | pcsrc);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      id_valid  <= 1'b0;
      id_instr  <= '0;
      id_pcplus <= '0;
    end else if (stall) begin
      pc        <= pc;
      id_valid  <= id_valid;
      id_instr  <= id_instr;
      id_pcplus <= id_pcplus;
    end else if (redirect) begin
      // Wrong-path fetch of this cycle is dropped by loading a bubble.
      pc        <= jmp ? jtarget : brtarget;
      id_valid  <= 1'b0;
      id_instr  <= '0;
      id_pcplus <= '0;
    end else begin
      pc        <= pcplus;
      id_valid  <= 1'b1;
      id_instr  <= instr;
      id_pcplus <= pcplus;
    end
  end

  assign op      = id_instr[31:26];
  assign funct   = id_instr[5:0];
  assign a1      = id_instr[25:21];
  assign a2      = id_instr[20:16];
  assign a3      = regdst ? id_instr[15:11] : id_instr[20:16];
  assign signimm = {{(XLEN-16){id_instr[15]}}, id_instr[15:0]};
  assign srca    = rd1;
  assign srcb    = alusrc ? signimm : rd2;
  assign wd3     = memtoreg ? readdata : aluresult;

endmodule

// File: tb/tb_mips_fetch_dpath_pipe.sv
// tb/tb_mips_fetch_dpath_pipe.sv - randomized model-checked bench for mips_fetch_dpath_pipe
module tb_mips_fetch_dpath_pipe;

  logic        clk = 1'b0;
  logic        rst, stall, pcsrc, jmp, memtoreg, alusrc, regdst;
  logic [31:0] instr, rd1, rd2, aluresult, readdata;

  logic [31:0] pc [2], id_instr [2], id_pcplus [2], signimm [2], srca [2], srcb [2], wd3 [2];
  logic        id_valid [2];
  logic [5:0]  op [2], funct [2];
  logic [4:0]  a1 [2], a2 [2], a3 [2];

  int total = 0;
  int bad   = 0;

  // Reference state per instance: 0 = byte addressed defaults, 1 = word addressed.
  logic [31:0] m_pc [2], m_ins [2], m_pp [2];
  logic        m_v [2];
  longint      stepv [2] = '{4, 1};
  int          shv [2]   = '{2, 0};
  logic [31:0] rpc [2]   = '{32'h0, 32'hFFFF_FFFF};

  always #5 clk = ~clk;

  mips_fetch_dpath_pipe u0 (
    .clk(clk), .rst(rst), .instr(instr), .stall(stall), .pcsrc(pcsrc), .jmp(jmp),
    .memtoreg(memtoreg), .alusrc(alusrc), .regdst(regdst), .rd1(rd1), .rd2(rd2),
    .aluresult(aluresult), .readdata(readdata), .pc(pc[0]), .id_valid(id_valid[0]),
    .id_instr(id_instr[0]), .id_pcplus(id_pcplus[0]), .op(op[0]), .funct(funct[0]),
    .a1(a1[0]), .a2(a2[0]), .a3(a3[0]), .signimm(signimm[0]), .srca(srca[0]),
    .srcb(srcb[0]), .wd3(wd3[0])
  );

  mips_fetch_dpath_pipe #(.XLEN(32), .RESET_PC(32'hFFFF_FFFF), .PC_STEP(1), .BR_SHIFT(0)) u1 (
    .clk(clk), .rst(rst), .instr(instr), .stall(stall), .pcsrc(pcsrc), .jmp(jmp),
    .memtoreg(memtoreg), .alusrc(alusrc), .regdst(regdst), .rd1(rd1), .rd2(rd2),
    .aluresult(aluresult), .readdata(readdata), .pc(pc[1]), .id_valid(id_valid[1]),
    .id_instr(id_instr[1]), .id_pcplus(id_pcplus[1]), .op(op[1]), .funct(funct[1]),
    .a1(a1[1]), .a2(a2[1]), .a3(a3[1]), .signimm(signimm[1]), .srca(srca[1]),
    .srcb(srcb[1]), .wd3(wd3[1])
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return 32'(longint'($signed(v)));
  endfunction

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      logic [31:0] si;
      si = sext16(m_ins[k][15:0]);
      chk($sformatf("pc%0d", k),        pc[k],        m_pc[k]);
      chk($sformatf("id_valid%0d", k),  id_valid[k],  m_v[k]);
      chk($sformatf("id_instr%0d", k),  id_instr[k],  m_ins[k]);
      chk($sformatf("id_pcplus%0d", k), id_pcplus[k], m_pp[k]);
      chk($sformatf("op%0d", k),        op[k],        m_ins[k] / 32'h0400_0000);
      chk($sformatf("funct%0d", k),     funct[k],     m_ins[k] % 64);
      chk($sformatf("a1_%0d", k),       a1[k],        (m_ins[k] >> 21) % 32);
      chk($sformatf("a2_%0d", k),       a2[k],        (m_ins[k] >> 16) % 32);
      chk($sformatf("a3_%0d", k),       a3[k],        regdst ? (m_ins[k] >> 11) % 32 : (m_ins[k] >> 16) % 32);
      chk($sformatf("signimm%0d", k),   signimm[k],   si);
      chk($sformatf("srca%0d", k),      srca[k],      rd1);
      chk($sformatf("srcb%0d", k),      srcb[k],      alusrc ? si : rd2);
      chk($sformatf("wd3_%0d", k),      wd3[k],       memtoreg ? readdata : aluresult);
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      longint pp, sc, bt, jt;
      pp = longint'(m_pp[k]);
      sc = longint'(1) << shv[k];
      bt = pp + longint'($signed(m_ins[k][15:0])) * sc;
      jt = ((pp >> (26 + shv[k])) << (26 + shv[k])) + longint'(m_ins[k][25:0]) * sc;
      if (rst) begin
        m_pc[k] = rpc[k]; m_v[k] = 1'b0; m_ins[k] = '0; m_pp[k] = '0;
      end else if (stall) begin
        // everything holds
      end else if (m_v[k] && (jmp || pcsrc)) begin
        m_pc[k] = jmp ? 32'(jt) : 32'(bt);
        m_v[k] = 1'b0; m_ins[k] = '0; m_pp[k] = '0;
      end else begin
        m_pp[k]  = 32'(longint'(m_pc[k]) + stepv[k]);
        m_pc[k]  = m_pp[k];
        m_ins[k] = instr;
        m_v[k]   = 1'b1;
      end
    end
  endtask

  // Called at a falling edge with inputs already applied; returns at the next falling edge.
  task automatic tick();
    #1;
    if (!rst) check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = 'x; m_v[k] = 1'b0; m_ins[k] = '0; m_pp[k] = '0;
    end
    rst = 1'b1; stall = 1'b0; pcsrc = 1'b0; jmp = 1'b0;
    memtoreg = 1'b0; alusrc = 1'b0; regdst = 1'b0;
    instr = 32'h2008_0005; rd1 = 32'h1111_1111; rd2 = 32'h2222_2222;
    aluresult = 32'h3333_3333; readdata = 32'h4444_4444;
    @(negedge clk);
    tick();
    chk("rst_pc", pc[0], 32'h0);
    chk("rst_valid", id_valid[0], 1'b0);
    chk("rst_op", op[0], 6'h0);
    chk("rst_pc_w", pc[1], 32'hFFFF_FFFF);
    rst = 1'b0;
    tick();
    chk("wrap_pc_w", pc[1], 32'h0);
    tick();
    chk("seq_pc", pc[0], 32'h8);
    chk("seq_valid", id_valid[0], 1'b1);
    chk("seq_op", op[0], 6'h08);
    chk("seq_a2", a2[0], 5'd8);
    chk("seq_imm", signimm[0], 32'h5);
    tick();
    // branch -1 fetched at 0x0C
    instr = 32'h1000_FFFF;
    tick();
    chk("br_pcplus", id_pcplus[0], 32'h10);
    instr = 32'h2008_0005; pcsrc = 1'b1;
    tick();
    chk("br_pc", pc[0], 32'h0C);
    chk("br_bubble", id_valid[0], 1'b0);
    tick();
    chk("bubble_no_redirect", pc[0], 32'h10);
    pcsrc = 1'b0;
    repeat (4) tick();
    instr = 32'h0800_0040;
    tick();
    chk("j_pcplus", id_pcplus[0], 32'h24);
    instr = 32'h2008_0005; jmp = 1'b1; pcsrc = 1'b1;
    tick();
    chk("j_pc", pc[0], 32'h100);
    chk("j_bubble", id_valid[0], 1'b0);
    jmp = 1'b0; pcsrc = 1'b0;
    repeat (2) tick();
    pcsrc = 1'b1; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc", pc[0], 32'h108);
      chk("stall_instr", id_instr[0], 32'h2008_0005);
    end
    stall = 1'b0;
    tick();
    chk("stall_redirect", pc[0], 32'h11C);
    pcsrc = 1'b0;
    tick();
    pcsrc = 1'b1; rst = 1'b1;
    tick();
    chk("rst_redirect_pc", pc[0], 32'h0);
    chk("rst_redirect_v", id_valid[0], 1'b0);
    rst = 1'b0; pcsrc = 1'b0;
    for (int n = 0; n < 600; n++) begin
      rst       = ($urandom_range(0, 40) == 0);
      stall     = ($urandom_range(0, 3) == 0);
      pcsrc     = ($urandom_range(0, 3) == 0);
      jmp       = ($urandom_range(0, 4) == 0);
      memtoreg  = $urandom_range(0, 1) == 1;
      alusrc    = $urandom_range(0, 1) == 1;
      regdst    = $urandom_range(0, 1) == 1;
      instr     = $urandom;
      rd1       = $urandom;
      rd2       = $urandom;
      aluresult = $urandom;
      readdata  = $urandom;
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
